// File: rtl/arb_pkg.sv
// Shared constants and state type for the four-channel round-robin arbiter.
package arb_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage : arb_pkg

// File: rtl/rr_pick4.sv
// Rotating-priority search: returns the first requesting channel after ptr,
// scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    logic [2*NUM_CH-1:0] dbl_s;
    logic [NUM_CH-1:0]   rot_s;
    logic [SEL_W-1:0]    off_s;

    // Rotate the request vector so bit 0 is the highest-priority channel, then priority-encode.
    always_comb begin
        dbl_s = {req, req};
        rot_s = dbl_s[(3'(ptr) + 3'd1) +: NUM_CH];
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
        idx   = ptr + 2'd1 + off_s;
        found = |req;
    end

endmodule : rr_pick4

// File: rtl/rr_arbiter_4ch.sv
// Four-channel round-robin arbiter with bounded bursts and a registered mux select.
// Optional per-channel grant counters are enabled by defining GRANT_CNT_EN.
module rr_arbiter_4ch
    import arb_pkg::*;
#(
    parameter int MAX_BEATS = 4,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       req,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        sel,
    output logic [NUM_CH-1:0]       grant,
    output logic                    valid
`ifdef GRANT_CNT_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] grant_cnt
`endif
);

    localparam int BEAT_W = $clog2(MAX_BEATS + 1);

    arb_state_t          state_q, state_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic [BEAT_W-1:0]   beats_q, beats_d;

    logic                found_s;
    logic [SEL_W-1:0]    pick_idx_s;
    logic                valid_s;
    logic                xfer_s;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (found_s),
        .idx   (pick_idx_s)
    );

    assign valid_s = (state_q == BUSY) & req[sel_q];
    assign xfer_s  = valid_s & out_ready;

    // Next-state: grant from IDLE, count beats in BUSY, release on dropped request or full burst.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        beats_d = beats_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    sel_d   = pick_idx_s;
                    grant_d = 4'b0001 << pick_idx_s;
                    beats_d = {BEAT_W{1'b0}};
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (!req[sel_q] || (xfer_s && (beats_q == BEAT_W'(MAX_BEATS - 1)))) begin
                    ptr_d   = sel_q;
                    grant_d = {NUM_CH{1'b0}};
                    beats_d = {BEAT_W{1'b0}};
                    state_d = IDLE;
                end else if (xfer_s) begin
                    beats_d = beats_q + BEAT_W'(1);
                end else begin
                    beats_d = beats_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = {NUM_CH{1'b0}};
                beats_d = {BEAT_W{1'b0}};
            end
        endcase
    end

`ifdef GRANT_CNT_EN
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of IDLE->BUSY grants per channel.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == IDLE) && found_s && (cnt_q[pick_idx_s] != {CNT_W{1'b1}})) begin
            cnt_d[pick_idx_s] = cnt_q[pick_idx_s] + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign grant_cnt = cnt_q;
`else
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

    // Arbiter state register; reset returns to IDLE with ch0 next in line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
            beats_q <= {BEAT_W{1'b0}};
`ifdef GRANT_CNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            beats_q <= beats_d;
`ifdef GRANT_CNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign sel   = sel_q;
    assign grant = grant_q;
    assign valid = valid_s;

endmodule : rr_arbiter_4ch

// File: tb/tb_rr_arbiter_4ch.sv
// Directed self-checking bench for rr_arbiter_4ch (MAX_BEATS=4; CNT_W=2 when GRANT_CNT_EN).
module tb_rr_arbiter_4ch;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
`ifdef GRANT_CNT_EN
    logic [7:0] grant_cnt;
`endif

    int n_checks;
    int n_fail;

    rr_arbiter_4ch #(
        .MAX_BEATS (4),
        .CNT_W     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .valid     (valid)
`ifdef GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_busy(input string tag, input logic [1:0] ch);
        check_eq({tag, "_grant"}, 32'(grant), 32'(4'b0001 << ch));
        check_eq({tag, "_sel"},   32'(sel),   32'(ch));
        check_eq({tag, "_valid"}, 32'(valid), 32'd1);
    endtask

    task automatic check_idle(input string tag, input logic [1:0] last_sel);
        check_eq({tag, "_grant"}, 32'(grant), 32'd0);
        check_eq({tag, "_sel"},   32'(sel),   32'(last_sel));
        check_eq({tag, "_valid"}, 32'(valid), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req       = 4'hF;
        out_ready = 1'b1;

        // Test 1: reset state, first grant to ch0, mid-burst reset
        #1;
        check_idle("reset", 2'd0);
        #11 rst = 1'b0;
        tick();
        check_busy("first_grant", 2'd0);
        tick();
        check_busy("ch0_beat1", 2'd0);
        #2 rst = 1'b1;
        #1;
        check_idle("mid_reset", 2'd0);
        #1 rst = 1'b0;
        tick();
        check_busy("post_reset_grant", 2'd0);

        // Test 2: rotation 0,1,2,3,0 with four beats each and one idle cycle between
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < 4; b++) begin
                check_busy($sformatf("rot_g%0d_b%0d", g, b), 2'(g % 4));
                tick();
            end
            check_idle($sformatf("rot_gap%0d", g), 2'(g % 4));
            tick();
        end

        // Test 3: ch1 now busy; drop all requests, then early release of ch2
        check_busy("rot_next_ch1", 2'd1);
        req = 4'b0000;
        #1;
        check_eq("drop_valid", 32'(valid), 32'd0);
        tick();
        check_idle("drop_release", 2'd1);
        tick();
        check_idle("stay_idle", 2'd1);
        req = 4'b0111;
        tick();
        check_busy("ch2_grant", 2'd2);
        tick();
        tick();
        check_busy("ch2_after2", 2'd2);
        req = 4'b0011;
        #1;
        check_eq("ch2_drop_valid", 32'(valid), 32'd0);
        tick();
        check_idle("ch2_release", 2'd2);
        tick();
        check_busy("after_ch2_pick0", 2'd0);

        // Test 4: backpressure on ch1 holds grant without counting beats
        req = 4'b0010;
        out_ready = 1'b0;
        tick();
        check_idle("ch0_release", 2'd0);
        tick();
        check_busy("ch1_grant", 2'd1);
        for (int c = 0; c < 10; c++) begin
            tick();
            check_busy($sformatf("stall_%0d", c), 2'd1);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_busy($sformatf("drain_%0d", c), 2'd1);
        end
        tick();
        check_idle("ch1_burst_end", 2'd1);

        // Test 5: sparse request to ch3, then ch0 wins over ch3 after ch3 served
        req = 4'b1000;
        tick();
        check_busy("ch3_grant", 2'd3);
        tick();
        tick();
        tick();
        check_busy("ch3_last_beat", 2'd3);
        req = 4'b1001;
        tick();
        check_idle("ch3_release", 2'd3);
        tick();
        check_busy("sparse_ch0", 2'd0);

`ifdef GRANT_CNT_EN
        // Test 6: five grants to ch0 saturate a 2-bit counter
        rst = 1'b1;
        #1;
        check_eq("cnt_reset", 32'(grant_cnt), 32'd0);
        rst = 1'b0;
        req = 4'b0001;
        for (int c = 0; c < 25; c++) begin
            tick();
        end
        check_eq("cnt_saturated", 32'(grant_cnt), 32'h03);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rr_arbiter_4ch
